// File: rtl/single_ram_bist_if.sv
// RAM bus between the BIST initiator (master) and the single-port RAM (slave).
interface single_ram_bist_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport master (output ram_en, ram_we, ram_addr, ram_din, input ram_dout);
  modport slave  (input ram_en, ram_we, ram_addr, ram_din, output ram_dout);
endinterface

// File: rtl/single_ram_bist.sv
// Fill/readback self-test for a single-port RAM with 1-cycle read latency; 66-cycle run.
// Optional SINGLE_RAM_BIST_FAIL_ADDR_EN adds first-mismatch address/data capture.
module single_ram_bist #(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 8,
  parameter int MEM_DEPTH     = 32,
  parameter int ERR_CNT_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    seed,
  single_ram_bist_if.master        ram,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
`ifdef SINGLE_RAM_BIST_FAIL_ADDR_EN
  ,
  output logic [ADDR_WIDTH-1:0]    fail_addr,
  output logic [DATA_WIDTH-1:0]    fail_data
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_TAIL, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

  state_t                state;
  logic [DATA_WIDTH-1:0] seed_q;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] exp_idx;
  logic                  rd_vld;
  logic                  en_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] din_q;

  function automatic logic [DATA_WIDTH-1:0] pat(input logic [DATA_WIDTH-1:0] s,
                                                input logic [ADDR_WIDTH-1:0] k);
    return DATA_WIDTH'(s + DATA_WIDTH'(k));
  endfunction

  assign ram.ram_en   = en_q;
  assign ram.ram_we   = we_q;
  assign ram.ram_addr = idx;
  assign ram.ram_din  = din_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      seed_q  <= '0;
      idx     <= '0;
      exp_idx <= '0;
      rd_vld  <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      din_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
`ifdef SINGLE_RAM_BIST_FAIL_ADDR_EN
      fail_addr <= '0;
      fail_data <= '0;
`endif
    end else begin
      // Read data arrives one cycle after the read, so compare against the delayed index.
      rd_vld  <= (state == S_READ);
      exp_idx <= idx;
      if (rd_vld && (ram.ram_dout != pat(seed_q, exp_idx))) begin
        err <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
`ifdef SINGLE_RAM_BIST_FAIL_ADDR_EN
        if (!err) begin
          fail_addr <= exp_idx;
          fail_data <= ram.ram_dout;
        end
`endif
      end

      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= S_WRITE;
            seed_q  <= seed;
            idx     <= '0;
            en_q    <= 1'b1;
            we_q    <= 1'b1;
            din_q   <= seed;
            busy    <= 1'b1;
            err     <= 1'b0;
            err_cnt <= '0;
`ifdef SINGLE_RAM_BIST_FAIL_ADDR_EN
            fail_addr <= '0;
            fail_data <= '0;
`endif
          end
        end
        S_WRITE: begin
          if (idx == LAST) begin
            state <= S_READ;
            idx   <= '0;
            we_q  <= 1'b0;
            din_q <= '0;
          end else begin
            idx   <= idx + ONE;
            din_q <= pat(seed_q, idx + ONE);
          end
        end
        S_READ: begin
          if (idx == LAST) begin
            state <= S_TAIL;
            idx   <= '0;
            en_q  <= 1'b0;
          end else begin
            idx <= idx + ONE;
          end
        end
        S_TAIL: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_single_ram_bist.sv
// Directed bench for single_ram_bist with a behavioural single-port RAM (sequential read pointer).
module tb_single_ram_bist;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] seed_in = 8'h00;
  logic       busy, done, err;
  logic [5:0] err_cnt;
`ifdef SINGLE_RAM_BIST_FAIL_ADDR_EN
  logic [4:0] fail_addr;
  logic [7:0] fail_data;
`endif

  int total = 0;
  int bad = 0;

  single_ram_bist_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) bus ();

  single_ram_bist dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .seed    (seed_in),
    .ram     (bus),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .err_cnt (err_cnt)
`ifdef SINGLE_RAM_BIST_FAIL_ADDR_EN
    ,
    .fail_addr (fail_addr),
    .fail_data (fail_data)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: 0 = correct, 1 = read of addr 7 returns 0x55, 2 = dout tied to 0
  int         ram_mode = 0;
  logic [7:0] mem [32];
  logic [4:0] rd_ptr;
  logic [7:0] dout_q;
  assign bus.ram_dout = dout_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      dout_q <= '0;
    end else if (bus.ram_en) begin
      if (bus.ram_we) begin
        mem[bus.ram_addr] <= bus.ram_din;
      end else begin
        if (ram_mode == 2)                        dout_q <= 8'h00;
        else if (ram_mode == 1 && rd_ptr == 5'd7) dout_q <= 8'h55;
        else                                      dout_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 5'd1;
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  int done_cyc, done_n, en_n, busy_c1, err_c1, cnt_c1;

  // Start one run and observe 90 cycles; cycle n is the n-th negedge after the accepting edge.
  task automatic run(input logic [7:0] s, input int mode, input int pulse_at, input int rst_at);
    ram_mode = mode;
    done_cyc = -1; done_n = 0; en_n = 0;
    @(negedge clk);
    start = 1'b1;
    seed_in = s;
    for (int n = 1; n <= 90; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == pulse_at) start = 1'b1;
      if (n == pulse_at + 1) start = 1'b0;
      if (n == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_ram_en", int'(bus.ram_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
      end
      if (n == rst_at + 2) rst = 1'b0;
      if (n == 1) begin
        busy_c1 = int'(busy);
        err_c1  = int'(err);
        cnt_c1  = int'(err_cnt);
      end
      if (bus.ram_en) en_n++;
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = n;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ram_en", int'(bus.ram_en), 0);
    check("reset_ram_we", int'(bus.ram_we), 0);
    check("reset_addr", int'(bus.ram_addr), 0);
    check("reset_din", int'(bus.ram_din), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err), 0);
    check("reset_err_cnt", int'(err_cnt), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(8'h00, 0, -10, -10);
    check("r1_done_cyc", done_cyc, 66);
    check("r1_done_n", done_n, 1);
    check("r1_busy_c1", busy_c1, 1);
    check("r1_en_cycles", en_n, 64);
    check("r1_mem0", int'(mem[0]), 8'h00);
    check("r1_mem31", int'(mem[31]), 8'h1F);
    check("r1_err", int'(err), 0);
    check("r1_err_cnt", int'(err_cnt), 0);
    check("r1_busy_end", int'(busy), 0);

    run(8'hF0, 0, -10, -10);
    check("r2_mem0f", int'(mem[15]), 8'hFF);
    check("r2_mem10", int'(mem[16]), 8'h00);
    check("r2_mem1f", int'(mem[31]), 8'h0F);
    check("r2_err", int'(err), 0);
    check("r2_done_cyc", done_cyc, 66);

    run(8'h00, 1, -10, -10);
    check("r3_err", int'(err), 1);
    check("r3_err_cnt", int'(err_cnt), 1);
`ifdef SINGLE_RAM_BIST_FAIL_ADDR_EN
    check("r3_fail_addr", int'(fail_addr), 7);
    check("r3_fail_data", int'(fail_data), 8'h55);
`endif

    run(8'h01, 2, -10, -10);
    check("r4_err", int'(err), 1);
    check("r4_err_cnt", int'(err_cnt), 32);
`ifdef SINGLE_RAM_BIST_FAIL_ADDR_EN
    check("r4_fail_addr", int'(fail_addr), 0);
    check("r4_fail_data", int'(fail_data), 0);
`endif

    run(8'h01, 0, -10, -10);
    check("r5_err_at_start", err_c1, 0);
    check("r5_cnt_at_start", cnt_c1, 0);
    check("r5_err", int'(err), 0);
    check("r5_err_cnt", int'(err_cnt), 0);

    run(8'h3C, 0, 10, -10);
    check("r6_done_n", done_n, 1);
    check("r6_done_cyc", done_cyc, 66);
    check("r6_en_cycles", en_n, 64);

    run(8'h00, 2, -10, 40);
    check("r7_done_n", done_n, 0);
    check("r7_busy", int'(busy), 0);
    check("r7_ram_en", int'(bus.ram_en), 0);

    run(8'h22, 0, -10, -10);
    check("r8_done_cyc", done_cyc, 66);
    check("r8_err", int'(err), 0);
    check("r8_mem5", int'(mem[5]), 8'h27);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/single_ram_bist.md
Name: single_ram_bist

Overview:
- Initiator/driver for the single-port RAM: owns the `ram_en`/`ram_we`/`addr`/`din` side and consumes `dout`.
- On a start pulse it fills every RAM location with a seeded pattern, reads the whole array back in sequential order, and compares each word.
- Reports busy, a done pulse, a sticky error flag and a saturating mismatch count.
- Sits next to the RAM as power-up/self-test logic and as the reference initiator for the RAM's write/read protocol.

Parameters:
- ADDR_WIDTH, 5, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- MEM_DEPTH, 32, number of locations exercised; equals 2**ADDR_WIDTH.
- ERR_CNT_WIDTH, 6, mismatch counter width; must hold MEM_DEPTH.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- seed  in  DATA_WIDTH  pattern seed, latched when start is accepted.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable (1 write, 0 read).
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_din  out  DATA_WIDTH  write data to RAM.
- ram_dout  in  DATA_WIDTH  registered read data from RAM.
- busy  out  1  high from the cycle after start acceptance through the TAIL cycle.
- done  out  1  one-cycle pulse in the cycle after TAIL.
- err  out  1  sticky mismatch flag; cleared on next accepted start.
- err_cnt  out  ERR_CNT_WIDTH  number of mismatches in the last run, saturating.

Behaviour:
- Reset is asynchronous and active-high. While rst is high, all outputs and state are 0 (ram_en, ram_we, ram_addr, ram_din, busy, done, err, err_cnt) and the state is IDLE.
- Pattern: pat(k) = (seed_q + k) truncated to DATA_WIDTH, where k is the address index and seed_q is the latched seed.

State machine:
- IDLE: ram_en=0.
  - start=1 latches seed, clears err and err_cnt, zeroes the index, and moves to WRITE.
  - start during any other state is ignored.
- WRITE: ram_en=1, ram_we=1, ram_addr=k, ram_din=pat(k) for k = 0..MEM_DEPTH-1, one location per cycle. After k=MEM_DEPTH-1 the index resets to 0 and the state moves to READ.
- READ: ram_en=1, ram_we=0, ram_addr=k for k = 0..MEM_DEPTH-1 (32 cycles). After the last read the state moves to TAIL.
- TAIL: one cycle, ram_en=0, ram_we=0. Captures the compare for the final read. Moves to DONE.
- DONE: one cycle, done=1, busy=0. Moves to IDLE.

Read alignment:
- RAM read latency is 1 cycle: the data for the read issued in cycle c is valid on ram_dout in cycle c+1.
- The compare uses a 1-cycle delayed valid and expected index; the compare for the read of k occurs in the cycle after that read is issued.
- The RAM serves reads from its own sequential read pointer, which wraps every MEM_DEPTH reads. The block always issues exactly MEM_DEPTH consecutive reads starting at index 0, so ram_addr and the RAM's pointer stay aligned across runs.
- ram_addr is still driven with the correct index.

Compare:
- On mismatch, err is set and err_cnt increments.
- err_cnt saturates at all-ones and never wraps.

Timing and boundaries:
- Total run: start accepted at edge E, busy rises at E. WRITE occupies 32 cycles, READ 32 cycles, TAIL 1 cycle; done pulses in cycle 66 after E. The next start can be accepted in the following cycle.
- Reset mid-run: outputs drop to 0 immediately. The RAM's read pointer may be left non-zero, so the RAM must also be reset or re-synchronised before the next run; the block does not compensate.
- start held high continuously: a new run starts on each return to IDLE.

Optional Feature:
- Macro: SINGLE_RAM_BIST_FAIL_ADDR_EN.
- Defined: adds outputs fail_addr [ADDR_WIDTH] and fail_data [DATA_WIDTH].
  - They capture the index and ram_dout value of the first mismatch in a run.
  - Cleared to 0 on reset and on accepted start; held until the next start.
- Undefined: these ports and their registers do not exist. All other behaviour is identical.

Test Plan:
- Reset, then start with seed=8'h00 against a correct RAM -> writes 0x00..0x1F to addr 0..31; done pulse 66 cycles after start; err=0, err_cnt=0.
- seed=8'hF0 -> ram_din at addr 0x0F is 8'hFF and at addr 0x10 is 8'h00 (wrap); no error.
- Force RAM dout to 8'h55 on the read of addr 7 only, seed=8'h00 -> err=1, err_cnt=1; with the macro defined, fail_addr=7 and fail_data=8'h55.
- Tie ram_dout=0 with seed=8'h01 -> err_cnt=32 and err=1; then start with a correct RAM and seed=8'h01 -> err and err_cnt cleared at start, end at 0.
- start pulsed at cycle 10 of a run -> ignored; exactly one done pulse; ram_en high for exactly 64 cycles.
- Assert rst at cycle 40 (mid-READ) -> ram_en, busy, err and err_cnt go to 0 asynchronously; no done pulse; state returns to IDLE.
